// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: register file, PC/IR/Y/Z/HI/LO/MAR/MDR, RAM, I/O ports, ALU and CON flag.
// Sequenced cycle-by-cycle by an external controller through one-hot strobes.
module datapath #(
    parameter int unsigned MEM_DEPTH = 512
) (
    input  logic        PCout,
    input  logic        ZLowout,
    input  logic        ZHighout,
    input  logic        MDRout,
    input  logic        MDRin,
    input  logic        MARin,
    input  logic        ZLowIn,
    input  logic        ZHighIn,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        Cout,
    input  logic        RAMin,
    input  logic        PCin,
    input  logic        IRin,
    input  logic        IncPC,
    input  logic        CONin,
    input  logic        Yin,
    input  logic        Read,
    input  logic        GRA,
    input  logic        GRB,
    input  logic        GRC,
    input  logic        BAout,
    input  logic        Rin,
    input  logic        Rout,
    input  logic        OutPortIn,
    input  logic        InPortIn,
    input  logic        InPortOut,
    input  logic [15:0] REGin,
    input  logic [15:0] REGout,
    output logic [4:0]  opcode,
    input  logic [31:0] Mdatain,
    input  logic [31:0] InPort_data,
    input  logic [31:0] OutPort_data,
    output logic [31:0] bus,
    input  logic        Clear,
    input  logic        Clock
);
    localparam int unsigned W  = 32;
    localparam int unsigned AW = $clog2(MEM_DEPTH);

    localparam logic [4:0] OP_LD = 5'd0,  OP_LDI = 5'd1,  OP_ST = 5'd2,   OP_ADD = 5'd3;
    localparam logic [4:0] OP_SUB = 5'd4, OP_AND = 5'd5,  OP_OR = 5'd6,   OP_SHR = 5'd7;
    localparam logic [4:0] OP_SHRA = 5'd8, OP_SHL = 5'd9, OP_ROR = 5'd10, OP_ROL = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI = 5'd14, OP_MUL = 5'd15;
    localparam logic [4:0] OP_DIV = 5'd16, OP_NEG = 5'd17, OP_NOT = 5'd18, OP_BR = 5'd19;

    logic [W-1:0] r [16];
    logic [W-1:0] pc, ir, y, z_hi, z_lo, hi, lo, mar, mdr, in_port, out_port;
    logic         con;
    logic [W-1:0] ram [MEM_DEPTH];

    logic [3:0]   sel;
    logic [15:0]  r_in, r_out;
    logic         ba_zero;
    logic [W-1:0] c_val, r0_val, ram_rd;
    logic [63:0]  alu_z, prod, rot_r, rot_l;
    logic [W-1:0] quot, rem;
    logic [4:0]   shamt;
    logic         con_next;
    logic         unused_sig;

    assign opcode     = ir[31:27];
    assign c_val      = {{13{ir[18]}}, ir[18:0]};
    assign ram_rd     = ram[mar[AW-1:0]];
    assign unused_sig = ^{Mdatain, OutPort_data, out_port, mar};

    // IR field select feeding the register enables
    always_comb begin
        sel = 4'd0;
        if (GRA)      sel = ir[26:23];
        else if (GRB) sel = ir[22:19];
        else if (GRC) sel = ir[18:15];
        for (int k = 0; k < 16; k++) begin
            r_in[k]  = REGin[k]  | (Rin && sel == 4'(k));
            r_out[k] = REGout[k] | ((Rout || BAout) && sel == 4'(k));
        end
        // BAout on R0 reads as zero for base+offset addressing
        ba_zero = BAout && (sel == 4'd0) && !Rout && !REGout[0];
        r0_val  = ba_zero ? '0 : r[0];
    end

    // Bus source priority mux
    always_comb begin
        bus = '0;
        if (r_out != 16'd0) begin
            for (int k = 15; k >= 1; k--) begin
                if (r_out[k]) bus = r[k];
            end
            if (r_out[0]) bus = r0_val;
        end
        else if (HIout)     bus = hi;
        else if (LOout)     bus = lo;
        else if (ZHighout)  bus = z_hi;
        else if (ZLowout)   bus = z_lo;
        else if (PCout)     bus = pc;
        else if (MDRout)    bus = mdr;
        else if (InPortOut) bus = in_port;
        else if (Cout)      bus = c_val;
    end

    // ALU: A = Y, B = bus
    always_comb begin
        shamt = bus[4:0];
        prod  = 64'($signed(y)) * 64'($signed(bus));
        rot_r = {y, y} >> shamt;
        rot_l = {y, y} << shamt;
        quot  = '0;
        rem   = '0;
        if (bus != '0) begin
            quot = 32'($signed(y) / $signed(bus));
            rem  = 32'($signed(y) % $signed(bus));
        end
        alu_z = '0;
        if (IncPC) alu_z[31:0] = bus + 32'd1;
        else begin
            case (opcode)
                OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI, OP_BR: alu_z[31:0] = y + bus;
                OP_SUB:          alu_z[31:0] = y - bus;
                OP_AND, OP_ANDI: alu_z[31:0] = y & bus;
                OP_OR, OP_ORI:   alu_z[31:0] = y | bus;
                OP_SHR:          alu_z[31:0] = y >> shamt;
                OP_SHRA:         alu_z[31:0] = 32'($signed(y) >>> shamt);
                OP_SHL:          alu_z[31:0] = y << shamt;
                OP_ROR:          alu_z[31:0] = rot_r[31:0];
                OP_ROL:          alu_z[31:0] = rot_l[63:32];
                OP_MUL:          alu_z       = prod;
                OP_DIV:          alu_z       = {rem, quot};
                OP_NEG:          alu_z[31:0] = 32'd0 - bus;
                OP_NOT:          alu_z[31:0] = ~bus;
                default:         alu_z[31:0] = bus;
            endcase
        end
    end

    always_comb begin
        case (ir[20:19])
            2'b00:   con_next = (bus == '0);
            2'b01:   con_next = (bus != '0);
            2'b10:   con_next = !bus[31];
            default: con_next = bus[31];
        endcase
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            for (int k = 0; k < 16; k++) r[k] <= '0;
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (r_in[k]) r[k] <= bus;
            end
        end
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            pc <= '0; ir <= '0; y <= '0; z_hi <= '0; z_lo <= '0; hi <= '0; lo <= '0;
            mar <= '0; mdr <= '0; in_port <= '0; out_port <= '0; con <= 1'b0;
        end else begin
            if (PCin)      pc       <= bus;
            if (IRin)      ir       <= bus;
            if (Yin)       y        <= bus;
            if (ZLowIn)    z_lo     <= alu_z[31:0];
            if (ZHighIn)   z_hi     <= alu_z[63:32];
            if (HIin)      hi       <= bus;
            if (LOin)      lo       <= bus;
            if (MARin)     mar      <= bus;
            if (MDRin)     mdr      <= Read ? ram_rd : bus;
            if (InPortIn)  in_port  <= InPort_data;
            if (OutPortIn) out_port <= bus;
            if (CONin)     con      <= con_next;
        end
    end

    // RAM contents survive Clear
    always_ff @(posedge Clock) begin
        if (RAMin) ram[mar[AW-1:0]] <= mdr;
    end
endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed fetch/store/branch/mul sequences plus randomized
// ALU, register-file and CON checks against a behavioural model.
module tb_datapath;
    logic        PCout, ZLowout, ZHighout, MDRout, MDRin, MARin, ZLowIn, ZHighIn, HIin, LOin;
    logic        HIout, LOout, Cout, RAMin, PCin, IRin, IncPC, CONin, Yin, Read, GRA, GRB, GRC;
    logic        BAout, Rin, Rout, OutPortIn, InPortIn, InPortOut;
    logic [15:0] REGin, REGout;
    logic [4:0]  opcode;
    logic [31:0] Mdatain, InPort_data, OutPort_data;
    logic [31:0] bus;
    logic        Clear, Clock;

    int checks = 0;
    int errors = 0;

    datapath dut (
        .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout), .MDRin(MDRin),
        .MARin(MARin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin),
        .HIout(HIout), .LOout(LOout), .Cout(Cout), .RAMin(RAMin), .PCin(PCin), .IRin(IRin),
        .IncPC(IncPC), .CONin(CONin), .Yin(Yin), .Read(Read), .GRA(GRA), .GRB(GRB), .GRC(GRC),
        .BAout(BAout), .Rin(Rin), .Rout(Rout), .OutPortIn(OutPortIn), .InPortIn(InPortIn),
        .InPortOut(InPortOut), .REGin(REGin), .REGout(REGout), .opcode(opcode),
        .Mdatain(Mdatain), .InPort_data(InPort_data), .OutPort_data(OutPort_data),
        .bus(bus), .Clear(Clear), .Clock(Clock)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic clear_ctrl();
        {PCout, ZLowout, ZHighout, MDRout, MDRin, MARin, ZLowIn, ZHighIn, HIin, LOin} = '0;
        {HIout, LOout, Cout, RAMin, PCin, IRin, IncPC, CONin, Yin, Read, GRA, GRB, GRC} = '0;
        {BAout, Rin, Rout, OutPortIn, InPortIn, InPortOut} = '0;
        REGin = '0; REGout = '0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        clear_ctrl();
    endtask

    task automatic put_in(input logic [31:0] v);
        InPort_data = v; InPortIn = 1'b1; tick();
    endtask

    task automatic load_reg(input int k, input logic [31:0] v);
        put_in(v); InPortOut = 1'b1; REGin = 16'(1) << k; tick();
    endtask

    task automatic load_ir(input logic [31:0] v);
        put_in(v); InPortOut = 1'b1; IRin = 1'b1; tick();
    endtask

    task automatic load_y(input logic [31:0] v);
        put_in(v); InPortOut = 1'b1; Yin = 1'b1; tick();
    endtask

    task automatic write_ram(input logic [31:0] addr, input logic [31:0] data);
        put_in(addr); InPortOut = 1'b1; MARin = 1'b1; tick();
        put_in(data); InPortOut = 1'b1; MDRin = 1'b1; tick();
        RAMin = 1'b1; tick();
    endtask

    task automatic do_clear();
        Clear = 1'b1; #2; Clear = 1'b0; #1;
    endtask

    // Behavioural ALU reference, written from the opcode table
    function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input bit inc);
        logic [63:0] res;
        logic [31:0] v;
        int          sa, sb, n;
        longint      p;
        res = '0; v = a; sa = a; sb = b; n = int'(b[4:0]);
        if (inc) return {32'd0, b + 32'd1};
        case (int'(op))
            0, 1, 2, 3, 12, 19: res[31:0] = a + b;
            4:       res[31:0] = a - b;
            5, 13:   res[31:0] = a & b;
            6, 14:   res[31:0] = a | b;
            7:  begin repeat (n) v = {1'b0, v[31:1]}; res[31:0] = v; end
            8:  begin repeat (n) v = {v[31], v[31:1]}; res[31:0] = v; end
            9:  begin repeat (n) v = {v[30:0], 1'b0}; res[31:0] = v; end
            10: begin repeat (n) v = {v[0], v[31:1]}; res[31:0] = v; end
            11: begin repeat (n) v = {v[30:0], v[31]}; res[31:0] = v; end
            15: begin p = longint'(sa) * longint'(sb); res = p; end
            16: if (sb != 0) res = {32'(sa % sb), 32'(sa / sb)};
            17:      res[31:0] = -b;
            18:      res[31:0] = ~b;
            default: res[31:0] = b;
        endcase
        return res;
    endfunction

    task automatic test_reset();
        Clear = 1'b1; clear_ctrl();
        Mdatain = '0; OutPort_data = '0; InPort_data = '0;
        #3;
        checks++; if (bus !== 32'd0) begin errors++; $display("FAIL reset_bus: got %h expected %h", bus, 32'd0); end
        checks++; if (opcode !== 5'd0) begin errors++; $display("FAIL reset_opcode: got %0d expected 0", opcode); end
        @(posedge Clock); #1; Clear = 1'b0;
        put_in(32'h0000_1234); InPortOut = 1'b1; PCin = 1'b1; tick();
        load_ir(32'hC800_0000);
        PCout = 1'b1; #1;
        checks++; if (bus !== 32'h1234) begin errors++; $display("FAIL pc_load: got %h expected %h", bus, 32'h1234); end
        checks++; if (opcode !== 5'd25) begin errors++; $display("FAIL ir_load_opcode: got %0d expected 25", opcode); end
        Clear = 1'b1; #1;
        checks++; if (bus !== 32'd0) begin errors++; $display("FAIL midrun_clear_pc: got %h expected 0", bus); end
        checks++; if (opcode !== 5'd0) begin errors++; $display("FAIL midrun_clear_opcode: got %0d expected 0", opcode); end
        PCout = 1'b0; InPortOut = 1'b1; #1;
        checks++; if (bus !== 32'd0) begin errors++; $display("FAIL midrun_clear_inport: got %h expected 0", bus); end
        Clear = 1'b0; clear_ctrl(); #1;
        checks++; if (bus !== 32'd0) begin errors++; $display("FAIL idle_bus: got %h expected 0", bus); end
    endtask

    task automatic test_fetch();
        do_clear();
        write_ram(32'd0, 32'h1090_0060);
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; tick();
        ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; tick();
        MDRout = 1'b1; IRin = 1'b1; tick();
        PCout = 1'b1; #1;
        checks++; if (bus !== 32'd1) begin errors++; $display("FAIL fetch_pc: got %h expected 1", bus); end
        checks++; if (opcode !== 5'd2) begin errors++; $display("FAIL fetch_opcode: got %0d expected 2", opcode); end
        checks++; if (dut.ir !== 32'h1090_0060) begin errors++; $display("FAIL fetch_ir: got %h expected %h", dut.ir, 32'h1090_0060); end
        clear_ctrl();
    endtask

    task automatic run_store();
        GRB = 1'b1; BAout = 1'b1; Yin = 1'b1; tick();
        Cout = 1'b1; ZLowIn = 1'b1; tick();
        ZLowout = 1'b1; MARin = 1'b1; tick();
        GRA = 1'b1; Rout = 1'b1; MDRin = 1'b1; tick();
        MDRout = 1'b1; RAMin = 1'b1; tick();
    endtask

    task automatic test_store();
        load_reg(2, 32'd5);
        load_reg(1, 32'h1A);
        run_store();
        checks++; if (dut.mar !== 32'h65) begin errors++; $display("FAIL st_mar: got %h expected %h", dut.mar, 32'h65); end
        MDRout = 1'b1; #1;
        checks++; if (bus !== 32'h1A) begin errors++; $display("FAIL st_mdr: got %h expected %h", bus, 32'h1A); end
        clear_ctrl();
        checks++; if (dut.ram[9'h65] !== 32'h1A) begin errors++; $display("FAIL st_ram: got %h expected %h", dut.ram[9'h65], 32'h1A); end
    endtask

    task automatic test_store_r0();
        load_ir(32'h1080_0060);
        load_reg(0, 32'd7);
        load_reg(1, 32'h55);
        GRB = 1'b1; BAout = 1'b1; #1;
        checks++; if (bus !== 32'd0) begin errors++; $display("FAIL baout_r0: got %h expected 0", bus); end
        GRB = 1'b0; BAout = 1'b0; REGout = 16'h0001; #1;
        checks++; if (bus !== 32'd7) begin errors++; $display("FAIL r0_regout: got %h expected 7", bus); end
        clear_ctrl();
        run_store();
        checks++; if (dut.mar !== 32'h60) begin errors++; $display("FAIL st_r0_mar: got %h expected %h", dut.mar, 32'h60); end
        checks++; if (dut.ram[9'h60] !== 32'h55) begin errors++; $display("FAIL st_r0_ram: got %h expected %h", dut.ram[9'h60], 32'h55); end
    endtask

    task automatic test_branch();
        logic [31:0] val;
        logic [1:0]  c2;
        bit          exp;
        load_ir((32'd19 << 27) | (32'd3 << 23) | (32'd1 << 19));
        load_reg(3, 32'd0);
        GRA = 1'b1; Rout = 1'b1; CONin = 1'b1; tick();
        checks++; if (dut.con !== 1'b0) begin errors++; $display("FAIL br_con_zero: got %b expected 0", dut.con); end
        load_reg(3, 32'd4);
        GRA = 1'b1; Rout = 1'b1; CONin = 1'b1; tick();
        checks++; if (dut.con !== 1'b1) begin errors++; $display("FAIL br_con_nonzero: got %b expected 1", dut.con); end
        for (int i = 0; i < 16; i++) begin
            c2  = 2'($urandom_range(0, 3));
            val = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
            case (c2)
                2'd0: exp = (val == 0);
                2'd1: exp = (val != 0);
                2'd2: exp = ($signed(val) >= 0);
                default: exp = ($signed(val) < 0);
            endcase
            load_ir((32'd19 << 27) | (32'd5 << 23) | (32'(c2) << 19));
            load_reg(5, val);
            GRA = 1'b1; Rout = 1'b1; CONin = 1'b1; tick();
            checks++; if (dut.con !== exp) begin errors++; $display("FAIL con_rand c2=%0d val=%h: got %b expected %b", c2, val, dut.con, exp); end
        end
    endtask

    task automatic test_mul();
        load_y(32'hFFFF_FFFD);
        load_ir(32'd15 << 27);
        put_in(32'd6); InPortOut = 1'b1; ZLowIn = 1'b1; ZHighIn = 1'b1; tick();
        ZHighout = 1'b1; #1;
        checks++; if (bus !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mul_zhigh: got %h expected %h", bus, 32'hFFFF_FFFF); end
        ZHighout = 1'b0; ZLowout = 1'b1; #1;
        checks++; if (bus !== 32'hFFFF_FFEE) begin errors++; $display("FAIL mul_zlow: got %h expected %h", bus, 32'hFFFF_FFEE); end
        clear_ctrl();
    endtask

    task automatic test_alu_random();
        logic [31:0] a, b;
        logic [4:0]  op;
        bit          inc;
        logic [63:0] exp;
        for (int i = 0; i < 60; i++) begin
            op  = 5'($urandom_range(0, 27));
            a   = $urandom();
            b   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
            if (op == 5'd16 && a == 32'h8000_0000) a = 32'd1;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 40));
            inc = ($urandom_range(0, 7) == 0);
            exp = alu_model(op, a, b, inc);
            load_y(a);
            load_ir(32'(op) << 27);
            put_in(b); InPortOut = 1'b1; ZLowIn = 1'b1; ZHighIn = 1'b1; IncPC = inc; tick();
            ZLowout = 1'b1; #1;
            checks++; if (bus !== exp[31:0]) begin errors++; $display("FAIL alu_zlow op=%0d a=%h b=%h inc=%0d: got %h expected %h", op, a, b, inc, bus, exp[31:0]); end
            ZLowout = 1'b0; ZHighout = 1'b1; #1;
            checks++; if (bus !== exp[63:32]) begin errors++; $display("FAIL alu_zhigh op=%0d a=%h b=%h: got %h expected %h", op, a, b, bus, exp[63:32]); end
            clear_ctrl();
        end
    endtask

    task automatic test_regfile();
        logic [31:0] model [16];
        int          i, j, k;
        logic [31:0] v;
        for (int n = 0; n < 16; n++) begin
            model[n] = $urandom();
            load_reg(n, model[n]);
        end
        for (int n = 0; n < 6; n++) begin
            k = $urandom_range(0, 15);
            v = $urandom();
            load_ir(32'(k) << 15);
            put_in(v); InPortOut = 1'b1; GRC = 1'b1; Rin = 1'b1; tick();
            model[k] = v;
            REGout = 16'(1) << k; #1;
            checks++; if (bus !== model[k]) begin errors++; $display("FAIL grc_rin R%0d: got %h expected %h", k, bus, model[k]); end
            clear_ctrl();
        end
        for (int n = 0; n < 8; n++) begin
            i = $urandom_range(0, 14);
            j = $urandom_range(i + 1, 15);
            REGout = (16'(1) << i) | (16'(1) << j); HIout = 1'b1; PCout = 1'b1; #1;
            checks++; if (bus !== model[i]) begin errors++; $display("FAIL bus_priority R%0d/R%0d: got %h expected %h", i, j, bus, model[i]); end
            clear_ctrl();
        end
        put_in(32'hABCD_0123); InPortOut = 1'b1; HIin = 1'b1; tick();
        put_in(32'h0F0F_F0F0); InPortOut = 1'b1; LOin = 1'b1; tick();
        HIout = 1'b1; LOout = 1'b1; #1;
        checks++; if (bus !== 32'hABCD_0123) begin errors++; $display("FAIL hi_over_lo: got %h expected %h", bus, 32'hABCD_0123); end
        HIout = 1'b0; #1;
        checks++; if (bus !== 32'h0F0F_F0F0) begin errors++; $display("FAIL lo_out: got %h expected %h", bus, 32'h0F0F_F0F0); end
        clear_ctrl();
    endtask

    task automatic test_ram_collision();
        write_ram(32'h10, 32'hDEAD_BEEF);
        put_in(32'h1357_9BDF); InPortOut = 1'b1; MDRin = 1'b1; tick();
        RAMin = 1'b1; Read = 1'b1; MDRin = 1'b1; tick();
        MDRout = 1'b1; #1;
        checks++; if (bus !== 32'hDEAD_BEEF) begin errors++; $display("FAIL collide_mdr: got %h expected %h", bus, 32'hDEAD_BEEF); end
        clear_ctrl();
        checks++; if (dut.ram[9'h10] !== 32'h1357_9BDF) begin errors++; $display("FAIL collide_ram: got %h expected %h", dut.ram[9'h10], 32'h1357_9BDF); end
        do_clear();
        put_in(32'h10); InPortOut = 1'b1; MARin = 1'b1; tick();
        Read = 1'b1; MDRin = 1'b1; tick();
        MDRout = 1'b1; #1;
        checks++; if (bus !== 32'h1357_9BDF) begin errors++; $display("FAIL ram_kept_after_clear: got %h expected %h", bus, 32'h1357_9BDF); end
        clear_ctrl();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_store_r0();
        test_branch();
        test_mul();
        test_alu_random();
        test_regfile();
        test_ram_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
